// File: rtl/pal_seq_pkg.sv
// Shared types and sizes for the palindrome sequencer slice.
package pal_seq_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEQ_W   = 64;
   localparam int MAX_LEN = 15;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/pal_digit_mux.sv
// Picks one 4-bit digit out of the packed request word.
// Digit 0 sits in the most significant nibble.
module pal_digit_mux
   import pal_seq_pkg::*;
(
   input  logic [SEQ_W-1:0]   seq,
   input  logic [LEN_W-1:0]   index,
   output logic [DIGIT_W-1:0] digit
);

   logic [SEQ_W-1:0] shifted;

   // Shift the wanted nibble up to the top, then take the top nibble
   always_comb begin
      shifted = seq << {index, 2'b00};
      digit   = shifted[SEQ_W-1 -: DIGIT_W];
   end

endmodule

// File: rtl/palindrome_sequencer.sv
// Drives an external palindrome detector.
// Each accepted request is turned into a clear phase, then a feed phase, then a wait
// for det_done, and finally a held response.
// Optional watchdog on the wait phase: define PAL_SEQ_TIMEOUT_EN.
module palindrome_sequencer
   import pal_seq_pkg::*;
#(
   parameter int CLEAR_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [LEN_W-1:0]   req_len,
   input  logic [SEQ_W-1:0]   req_seq,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_pal,
   output logic [SEQ_W-1:0]   rsp_num,
   output logic               rsp_err,
   output logic               det_reset,
   output logic [DIGIT_W-1:0] det_a,
   output logic [LEN_W-1:0]   det_b,
   input  logic [SEQ_W-1:0]   det_c,
   input  logic               det_d,
   input  logic               det_done,
   output logic               busy
);

   localparam logic [LEN_W-1:0] CLEAR_LAST = LEN_W'(CLEAR_CYCLES - 1);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               rsp_pal_q, rsp_pal_d;
   logic [SEQ_W-1:0]   rsp_num_q, rsp_num_d;
   logic               rsp_err_q, rsp_err_d;
   logic [DIGIT_W-1:0] feed_digit;

`ifdef PAL_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wdog_q, wdog_d;

   // Watchdog counter: counts consecutive WAIT cycles, cleared everywhere else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   // The same counter serves as CLEAR cycle count and FEED digit index
   pal_digit_mux u_digit_mux (
      .seq   (seq_q),
      .index (cnt_q),
      .digit (feed_digit)
   );

   // State, latched request and captured response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         seq_q     <= '0;
         cnt_q     <= '0;
         rsp_pal_q <= 1'b0;
         rsp_num_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         seq_q     <= seq_d;
         cnt_q     <= cnt_d;
         rsp_pal_q <= rsp_pal_d;
         rsp_num_q <= rsp_num_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Next-state logic plus all outputs decoded from the current state
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      seq_d     = seq_q;
      cnt_d     = cnt_q;
      rsp_pal_d = rsp_pal_q;
      rsp_num_d = rsp_num_q;
      rsp_err_d = rsp_err_q;
`ifdef PAL_SEQ_TIMEOUT_EN
      wdog_d    = '0;
`endif

      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
      det_reset = !((state_q == FEED) || (state_q == WAIT));
      det_a     = (state_q == FEED) ? feed_digit : '0;
      det_b     = ((state_q == CLEAR) || (state_q == FEED) || (state_q == WAIT)) ? len_q : '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               len_d = req_len;
               seq_d = req_seq;
               cnt_d = '0;
               if (req_len == '0) begin
                  rsp_pal_d = 1'b0;
                  rsp_num_d = '0;
                  rsp_err_d = 1'b1;
                  state_d   = RESP;
               end else begin
                  state_d   = CLEAR;
               end
            end
         end
         CLEAR: begin
            if (cnt_q == CLEAR_LAST) begin
               cnt_d   = '0;
               state_d = FEED;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         FEED: begin
            if (cnt_q == len_q - 1'b1) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         WAIT: begin
            if (det_done) begin
               rsp_pal_d = det_d;
               rsp_num_d = det_c;
               rsp_err_d = 1'b0;
               state_d   = RESP;
`ifdef PAL_SEQ_TIMEOUT_EN
            end else if (wdog_q == WD_LAST) begin
               rsp_pal_d = 1'b0;
               rsp_num_d = '0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               wdog_d    = wdog_q + 1'b1;
`endif
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rsp_pal = rsp_pal_q;
   assign rsp_num = rsp_num_q;
   assign rsp_err = rsp_err_q;

endmodule
